// File: rtl/boot_loader.sv
// Serial boot loader: takes a length-prefixed, checksummed word stream and writes it into program flash.
// One flash write cycle per received word; the block stalls the byte stream during that cycle.
module boot_loader (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        flash_we,
    output logic [11:0] flash_waddr,
    output logic [15:0] flash_wdata,
    output logic        bootstrapping,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_len_hi;
    logic [11:0] r_n;
    logic [11:0] r_addr;
    logic [11:0] r_wcnt;
    logic [7:0]  r_sum;
    logic [7:0]  r_hi;
    logic [11:0] r_waddr;
    logic [15:0] r_wdata;

    logic        w_rdy;
    logic        w_acc;
    logic        w_start_ok;
    logic [11:0] w_len;
    logic        w_len_bad;
    logic [7:0]  w_sum_next;
    logic        w_last;

    // rx_ready is decoded from the state register only, so rx_valid never reaches it.
    assign w_acc      = rx_valid && w_rdy;
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_len      = {r_len_hi[3:0], rx_data};
    assign w_len_bad  = (r_len_hi[7:4] != 4'h0) || (w_len == 12'h000);
    assign w_sum_next = r_sum + rx_data;
    assign w_last     = ((r_wcnt + 12'd1) == r_n);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_acc) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_acc) w_next = w_len_bad ? S_ERR : S_DATA_HI;
            end
            S_DATA_HI: begin
                if (w_acc) w_next = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (w_acc) w_next = S_WRITE;
            end
            S_WRITE: begin
                w_next = w_last ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: begin
                if (w_acc) w_next = (w_sum_next == 8'h00) ? S_DONE : S_ERR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdy         = 1'b0;
        flash_we      = 1'b0;
        bootstrapping = 1'b1;
        done          = 1'b0;
        error         = 1'b0;
        case (r_state)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: w_rdy = 1'b1;
            S_WRITE: flash_we = 1'b1;
            S_DONE: begin
                done          = 1'b1;
                bootstrapping = 1'b0;
            end
            S_ERR: error = 1'b1;
            default: ;
        endcase
    end

    assign rx_ready    = w_rdy;
    assign flash_waddr = r_waddr;
    assign flash_wdata = r_wdata;

    // Datapath; the write address/data registers are loaded on the low byte so they are stable for the whole WRITE cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_len_hi <= 8'h00;
            r_n      <= 12'h000;
            r_addr   <= 12'h000;
            r_wcnt   <= 12'h000;
            r_sum    <= 8'h00;
            r_hi     <= 8'h00;
            r_waddr  <= 12'h000;
            r_wdata  <= 16'h0000;
        end else begin
            if (w_start_ok) begin
                r_addr <= 12'h000;
                r_wcnt <= 12'h000;
                r_sum  <= 8'h00;
            end
            case (r_state)
                S_LEN_HI: begin
                    if (w_acc) r_len_hi <= rx_data;
                end
                S_LEN_LO: begin
                    if (w_acc) r_n <= w_len;
                end
                S_DATA_HI: begin
                    if (w_acc) begin
                        r_hi  <= rx_data;
                        r_sum <= w_sum_next;
                    end
                end
                S_DATA_LO: begin
                    if (w_acc) begin
                        r_sum   <= w_sum_next;
                        r_waddr <= r_addr;
                        r_wdata <= {r_hi, rx_data};
                    end
                end
                S_WRITE: begin
                    r_addr <= r_addr + 12'd1;
                    r_wcnt <= r_wcnt + 12'd1;
                end
                S_CHECK: begin
                    if (w_acc) r_sum <= w_sum_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL be reset asynchronously and otherwise update on the rising clock edge.
REQ-002 clk  in  1  system clock.
REQ-003 arst  in  1  asynchronous active-high reset.
REQ-004 start  in  1  one-cycle request to begin a load; sampled only in IDLE, DONE and ERR.
REQ-005 rx_data  in  8  incoming byte.
REQ-006 rx_valid  in  1  rx_data valid; a byte transfers when rx_valid && rx_ready.
REQ-007 rx_ready  out  1  block can accept a byte this cycle.
REQ-008 flash_we  out  1  one-cycle write strobe to program flash.
REQ-009 flash_waddr  out  12  word address written, matching the core's 12-bit pc_out space.
REQ-010 flash_wdata  out  16  instruction word written, matching the core's 16-bit flash_data.
REQ-011 bootstrapping  out  1  high holds the core in bootstrap; low releases it.
REQ-012 done  out  1  load completed with a good checksum.
REQ-013 error  out  1  load aborted: bad header or bad checksum.

Function
REQ-014 Frame format SHALL be: LEN_HI, LEN_LO, then N words, each sent as high byte then low byte, then CHK, where N = {LEN_HI[3:0], LEN_LO}.
REQ-015 Valid N SHALL be 1..4095; LEN_HI[7:4] != 0 or N == 0 SHALL go to ERR immediately after LEN_LO is accepted.
REQ-016 The FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE and ERR.
REQ-017 IDLE/DONE/ERR + start -> LEN_HI; the block SHALL clear the address counter, word counter, checksum accumulator, done and error, and SHALL set bootstrapping.
REQ-018 rx_ready SHALL be 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; each state SHALL advance only on an accepted byte.
REQ-019 DATA_LO accept -> WRITE; WRITE SHALL last exactly one cycle with flash_we=1, flash_waddr=counter, flash_wdata={hi,lo}, and rx_ready=0.
REQ-020 After WRITE, the address SHALL increment; if the words written equal N the FSM SHALL go to CHECK, otherwise to DATA_HI.
REQ-021 The checksum SHALL be the 8-bit modular sum of all data bytes plus CHK, with LEN bytes excluded; a result of 8'h00 -> DONE, any other value -> ERR.
REQ-022 flash_we SHALL never assert outside WRITE, and the address SHALL never wrap, because N <= 4095.
REQ-023 DONE: done=1 and bootstrapping=0, held until the next start.
REQ-024 ERR: error=1 and bootstrapping=1, held until the next start; words already written are not rolled back.
REQ-025 start outside IDLE/DONE/ERR SHALL be ignored; rx_valid with rx_ready=0 SHALL be ignored without side effects.
REQ-026 flash_waddr and flash_wdata SHALL hold their last values when flash_we=0.
REQ-027 Implementation SHALL be fully synchronous apart from arst, with no combinational path from rx_valid to rx_ready.

Reset
REQ-028 While arst=1 and after release: state=IDLE, rx_ready=0, flash_we=0, flash_waddr=0, flash_wdata=0, bootstrapping=1, done=0, error=0.
REQ-029 arst asserted mid-load SHALL abort at once with no further flash_we; IDLE values per REQ-028 apply.

Verification
REQ-030 start; bytes 00 02 61 0A 00 00 95 -> writes (0,16'h610A), (1,16'h0000); done=1, bootstrapping=0.
REQ-031 Same frame with CHK=96 -> two writes, then error=1, bootstrapping=1, done=0.
REQ-032 start; bytes 10 01 -> error=1 after LEN_LO; no flash_we. Bytes 00 00 -> same result.
REQ-033 Random rx_valid gaps, one valid every 1-5 cycles -> identical write sequence to the gap-free case; rx_ready=0 in every WRITE cycle.
REQ-034 arst pulsed after the first word is written -> no further flash_we; outputs per REQ-028; new start plus a full frame completes normally from address 0.
REQ-035 start pulsed while in DATA_HI -> ignored; the frame completes unaffected.
